// File: rtl/uart_rx_cmd.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cmd
// Purpose  : Oversampling UART receiver with registered one-hot command decode.
//            Optional parity bit enabled by defining UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cmd #(
   parameter int                            DATA_BITS  = 8,
   parameter int                            OVERSAMPLE = 16,
   parameter int                            NUM_CMDS   = 4,
   parameter logic [NUM_CMDS*DATA_BITS-1:0] CMD_CODES  = {8'h4D, 8'h43, 8'h53, 8'h52},
   parameter int                            PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 cmd_valid,
   output logic [NUM_CMDS-1:0]  cmd_onehot
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [TICK_W-1:0] c_tick_half = TICK_W'(OVERSAMPLE/2 - 1);
   localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] c_tick_one  = TICK_W'(1);
   localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  c_bit_one   = BIT_W'(1);

   generate
      if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
          PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
         $error("uart_rx_cmd: illegal parameter set");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
      , S_PARITY  = 3'd5
`endif
   } state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_rx_meta, r_rx_s;
   logic [TICK_W-1:0]     r_tick_cnt, w_tick_nxt;
   logic [BIT_W-1:0]      r_bit_cnt, w_bit_nxt;
   logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
   logic [DATA_BITS-1:0]  r_rx_data;
   logic                  r_rx_done, r_frame_err, r_parity_err;
   logic                  w_done, w_ferr, w_perr;
   logic                  r_cmd_valid, w_match_any;
   logic [NUM_CMDS-1:0]   r_cmd_onehot, w_match_onehot;
`ifdef UART_RX_PARITY_EN
   localparam logic c_par_odd = (PARITY_ODD != 0);
   logic                  r_par_bad, w_par_bad_nxt;
`endif

   // Both synchronizer flops reset high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_rx_data    <= '0;
         r_rx_done    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_tick_cnt   <= w_tick_nxt;
         r_bit_cnt    <= w_bit_nxt;
         r_shift      <= w_shift_nxt;
         r_rx_done    <= w_done;
         r_frame_err  <= w_ferr;
         r_parity_err <= w_perr;
         if (w_done)
            r_rx_data <= r_shift;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= w_par_bad_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_done      = 1'b0;
      w_ferr      = 1'b0;
      w_perr      = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nxt = r_par_bad;
`endif
      case (r_state)
         S_IDLE: begin
            w_tick_nxt = '0;
            w_bit_nxt  = '0;
            if (!r_rx_s)
               w_state_nxt = S_START;
         end
         S_START: begin
            if (tick) begin
               if (r_tick_cnt == c_tick_half) begin
                  w_tick_nxt  = '0;
                  w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
               end else begin
                  w_tick_nxt = r_tick_cnt + c_tick_one;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (r_tick_cnt == c_tick_last) begin
                  w_tick_nxt              = '0;
                  w_shift_nxt[r_bit_cnt]  = r_rx_s;
                  if (r_bit_cnt == c_bit_last) begin
                     w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = S_PARITY;
`else
                     w_state_nxt = S_STOP;
`endif
                  end else begin
                     w_bit_nxt = r_bit_cnt + c_bit_one;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + c_tick_one;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               if (r_tick_cnt == c_tick_last) begin
                  w_tick_nxt    = '0;
                  w_par_bad_nxt = r_rx_s ^ (^r_shift) ^ c_par_odd;
                  w_state_nxt   = S_STOP;
               end else begin
                  w_tick_nxt = r_tick_cnt + c_tick_one;
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (r_tick_cnt == c_tick_last) begin
                  w_tick_nxt = '0;
                  // Framing error wins over a parity mismatch.
                  if (!r_rx_s) begin
                     w_ferr      = 1'b1;
                     w_state_nxt = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                  end else if (r_par_bad) begin
                     w_perr      = 1'b1;
                     w_state_nxt = S_IDLE;
`endif
                  end else begin
                     w_done      = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + c_tick_one;
               end
            end
         end
         S_WAIT_HIGH: begin
            w_tick_nxt = '0;
            if (r_rx_s)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Scan from the top down so the lowest matching index is the one kept.
   always_comb begin
      w_match_any    = 1'b0;
      w_match_onehot = '0;
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
         if (r_rx_data == CMD_CODES[i*DATA_BITS +: DATA_BITS]) begin
            w_match_any       = 1'b1;
            w_match_onehot    = '0;
            w_match_onehot[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cmd_valid  <= 1'b0;
         r_cmd_onehot <= '0;
      end else if (r_rx_done) begin
         r_cmd_valid  <= w_match_any;
         r_cmd_onehot <= w_match_onehot;
      end else begin
         r_cmd_valid  <= 1'b0;
         r_cmd_onehot <= '0;
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_done    = r_rx_done;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign cmd_valid  = r_cmd_valid;
   assign cmd_onehot = r_cmd_onehot;

endmodule
`default_nettype wire
